// File: rtl/rs_gf_pkg.sv
// rtl/rs_gf_pkg.sv - GF(2^8) arithmetic, Chien constants and FSM states for the t=2 RS decoder
package rs_gf_pkg;

  localparam int         SEG_LEN_DEF = 176;
  localparam logic [7:0] GF_POLY_LOW = 8'h1D;  // x^8 = x^4+x^3+x^2+1

  typedef enum logic [2:0] {IDLE, CALC, INV_A, SIGMA, INV_B, CHIEN, DONE} rs_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY_LOW : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  function automatic logic [7:0] gf_alpha_pow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  localparam logic [7:0] ALPHA_TOP = gf_alpha_pow(SEG_LEN_DEF - 1);
  localparam logic [7:0] ALPHA_INV = 8'h8E;

endpackage

// File: rtl/rs_gf_inv.sv
// rtl/rs_gf_inv.sv - iterative GF(2^8) inverse a^254 over 7 cycles.
// done is high in the final iteration; result is valid from the next cycle and held until start.
module rs_gf_inv import rs_gf_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] operand,
  output logic [7:0] result,
  output logic       done
);

  logic [7:0] acc;
  logic [7:0] pw;
  logic [2:0] step;
  logic       active;

  // a^254 = product of a^(2^k) for k = 1..7, one factor per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= 8'h01;
      pw     <= 8'h00;
      step   <= 3'd0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= 8'h01;
      pw     <= gf_sq(operand);
      step   <= 3'd0;
      active <= 1'b1;
    end else if (active) begin
      acc  <= gf_mul(acc, pw);
      pw   <= gf_sq(pw);
      step <= step + 3'd1;
      if (step == 3'd6) active <= 1'b0;
    end
  end

  assign result = acc;
  assign done   = active && (step == 3'd6);

endmodule

// File: rtl/rs_error_locator.sv
// rtl/rs_error_locator.sv - t=2 RS error locator: Peterson solve, Chien search, error values.
// Optional RS_CHIEN_EARLY_EXIT_EN ends the Chien search once the expected hits are found.
module rs_error_locator import rs_gf_pkg::*; #(
  parameter int SEG_LEN = 176
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       synReady,
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  output logic       busy,
  output logic       errValid,
  output logic [7:0] errPos,
  output logic [7:0] errMag,
  output logic       done,
  output logic [1:0] errCount,
  output logic       uncorrectable
);

  localparam logic [7:0] X_START = (SEG_LEN == SEG_LEN_DEF) ? ALPHA_TOP : gf_alpha_pow(SEG_LEN - 1);
  localparam logic [7:0] IDX_END = 8'(SEG_LEN);

  rs_state_e  state, nextState;
  logic [7:0] syn0, syn1, syn2, syn3;
  logic       twoErr;
  logic [7:0] sig1, sig2, x1;
  logic [7:0] xCur, idx;
  logic [1:0] hitCount;

  logic [7:0] invResult, invOperand;
  logic       invStart, invDone;

  logic [7:0] det, sigma1C, sigma2C, x1C, quad, chienMag;
  logic       allZero, oneOk, earlyStop, chienScan, chienHit, finUnc;
  logic [1:0] required, finCount;

  rs_gf_inv invUnit (
    .clk     (clk),
    .reset   (reset),
    .start   (invStart),
    .operand (invOperand),
    .result  (invResult),
    .done    (invDone)
  );

  // invResult is det^-1 / S0^-1 during SIGMA and sigma1^-1 during CHIEN
  assign det      = gf_sq(syn1) ^ gf_mul(syn0, syn2);
  assign allZero  = ({syn0, syn1, syn2, syn3} == 32'h0);
  assign sigma1C  = gf_mul(gf_mul(syn0, syn3) ^ gf_mul(syn1, syn2), invResult);
  assign sigma2C  = gf_mul(gf_mul(syn1, syn3) ^ gf_sq(syn2), invResult);
  assign x1C      = gf_mul(syn1, invResult);
  assign oneOk    = (syn2 == gf_mul(syn1, x1C)) && (syn3 == gf_mul(syn2, x1C));
  assign required = twoErr ? 2'd2 : 2'd1;

  assign quad      = gf_sq(xCur) ^ gf_mul(sig1, xCur) ^ sig2;
  assign chienScan = (state == CHIEN) && (idx != IDX_END) && !earlyStop;
  assign chienHit  = chienScan && (twoErr ? (quad == 8'h00) : (xCur == x1));
  assign chienMag  = twoErr ? gf_mul(syn1 ^ gf_mul(syn0, xCur) ^ gf_mul(syn0, sig1), invResult) : syn0;

  always_comb begin
`ifdef RS_CHIEN_EARLY_EXIT_EN
    earlyStop = (hitCount == required);
`else
    earlyStop = 1'b0;
`endif
  end

  always_comb begin
    nextState  = state;
    invStart   = 1'b0;
    invOperand = 8'h01;
    finCount   = 2'd0;
    finUnc     = 1'b0;
    case (state)
      IDLE: nextState = IDLE;
      CALC: begin
        if (allZero) begin
          nextState = DONE;
        end else if (det != 8'h00) begin
          nextState  = INV_A;
          invStart   = 1'b1;
          invOperand = det;
        end else if (syn0 != 8'h00) begin
          nextState  = INV_A;
          invStart   = 1'b1;
          invOperand = syn0;
        end else begin
          nextState = DONE;
          finUnc    = 1'b1;
        end
      end
      INV_A: if (invDone) nextState = SIGMA;
      SIGMA: begin
        if (twoErr ? (sigma1C == 8'h00 || sigma2C == 8'h00) : !oneOk) begin
          nextState = DONE;
          finUnc    = 1'b1;
        end else begin
          // the one-error path inverts 1 only to keep latency identical
          nextState  = INV_B;
          invStart   = 1'b1;
          invOperand = twoErr ? sigma1C : 8'h01;
        end
      end
      INV_B: if (invDone) nextState = CHIEN;
      CHIEN: begin
        if (idx == IDX_END || earlyStop) begin
          nextState = DONE;
          finCount  = hitCount;
          finUnc    = (hitCount != required);
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (synReady) begin
      nextState = CALC;
      invStart  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      errValid      <= 1'b0;
      errPos        <= 8'h00;
      errMag        <= 8'h00;
      done          <= 1'b0;
      errCount      <= 2'd0;
      uncorrectable <= 1'b0;
      syn0          <= 8'h00;
      syn1          <= 8'h00;
      syn2          <= 8'h00;
      syn3          <= 8'h00;
      twoErr        <= 1'b0;
      sig1          <= 8'h00;
      sig2          <= 8'h00;
      x1            <= 8'h00;
      xCur          <= 8'h00;
      idx           <= 8'h00;
      hitCount      <= 2'd0;
    end else begin
      state    <= nextState;
      busy     <= (nextState != IDLE);
      done     <= (nextState == DONE);
      errValid <= chienHit && !synReady;
      if (chienHit) begin
        errPos <= idx;
        errMag <= chienMag;
      end
      if (nextState == DONE) begin
        errCount      <= finCount;
        uncorrectable <= finUnc;
      end
      if (synReady) begin
        syn0          <= s0;
        syn1          <= s1;
        syn2          <= s2;
        syn3          <= s3;
        errCount      <= 2'd0;
        uncorrectable <= 1'b0;
      end
      if (state == CALC) twoErr <= (det != 8'h00);
      if (state == SIGMA) begin
        sig1     <= sigma1C;
        sig2     <= sigma2C;
        x1       <= x1C;
        xCur     <= X_START;
        idx      <= 8'h00;
        hitCount <= 2'd0;
      end
      if (chienScan) begin
        xCur <= gf_mul(xCur, ALPHA_INV);
        idx  <= idx + 8'd1;
      end
      if (chienHit) hitCount <= hitCount + 2'd1;
    end
  end

endmodule

// File: tb/tb_rs_error_locator.sv
// tb/tb_rs_error_locator.sv - directed self-checking bench for rs_error_locator
`timescale 1ns/1ps
module tb_rs_error_locator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       synReady = 1'b0;
  logic [7:0] s0 = 8'h00, s1 = 8'h00, s2 = 8'h00, s3 = 8'h00;
  logic       busy, errValid, done, uncorrectable;
  logic [7:0] errPos, errMag;
  logic [1:0] errCount;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tStart = 0;
  int evK[$];
  int evPos[$];
  int evMag[$];
  int doneK, doneSeen, doneCnt, doneUnc, busyFirst, busyAfter;

`ifdef RS_CHIEN_EARLY_EXIT_EN
  localparam int DONE_TWO = 193;
`else
  localparam int DONE_TWO = 194;
`endif

  rs_error_locator #(.SEG_LEN(176)) dut (
    .clk           (clk),
    .reset         (reset),
    .synReady      (synReady),
    .s0            (s0),
    .s1            (s1),
    .s2            (s2),
    .s3            (s3),
    .busy          (busy),
    .errValid      (errValid),
    .errPos        (errPos),
    .errMag        (errMag),
    .done          (done),
    .errCount      (errCount),
    .uncorrectable (uncorrectable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [7:0] tb_pow(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = tb_mul(r, b);
    return r;
  endfunction

  // errors 0x80 at idx 10 (locator a^165) and 0x01 at idx 174 (locator a^1)
  function automatic logic [7:0] two_syn(input int j);
    return tb_mul(8'h80, tb_pow(tb_pow(8'h02, 165), j)) ^ tb_pow(8'h02, j);
  endfunction

  // caller must be at a falling edge; synReady is high for this one cycle
  task automatic start_now(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    s0 = a; s1 = b; s2 = c; s3 = d;
    synReady = 1'b1;
    tStart = cyc;
    @(negedge clk);
    synReady = 1'b0;
  endtask

  task automatic start_two();
    start_now(two_syn(0), two_syn(1), two_syn(2), two_syn(3));
  endtask

  task automatic observe(input int maxK);
    int k;
    evK.delete(); evPos.delete(); evMag.delete();
    doneK = -1; doneSeen = 0; doneCnt = -1; doneUnc = -1; busyFirst = -1; busyAfter = -1;
    while (1) begin
      k = cyc - tStart;
      if (k == 1) busyFirst = busy;
      if (doneSeen > 0 && k == doneK + 1) begin
        busyAfter = busy;
        break;
      end
      if (errValid) begin
        evK.push_back(k); evPos.push_back(errPos); evMag.push_back(errMag);
      end
      if (done) begin
        doneSeen++; doneK = k; doneCnt = errCount; doneUnc = uncorrectable;
      end
      if (k >= maxK) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, errValid, done, uncorrectable} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, errValid, done, uncorrectable});
    end
    checks++;
    if ({errPos, errMag} !== 16'h0000) begin
      errors++; $display("FAIL reset_pos_mag: got %h want 0000", {errPos, errMag});
    end
    checks++;
    if (errCount !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", errCount); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    @(negedge clk);
    start_now(8'h00, 8'h00, 8'h00, 8'h00);
    observe(20);
    checks++; if (doneK != 2) begin errors++; $display("FAIL zero_done_time: got %0d want 2", doneK); end
    checks++; if (doneCnt != 0) begin errors++; $display("FAIL zero_count: got %0d want 0", doneCnt); end
    checks++; if (doneUnc != 0) begin errors++; $display("FAIL zero_unc: got %0d want 0", doneUnc); end
    checks++; if (evK.size() != 0) begin errors++; $display("FAIL zero_errvalid: got %0d want 0", evK.size()); end
    checks++; if (busyFirst != 1) begin errors++; $display("FAIL zero_busy_start: got %0d want 1", busyFirst); end
    checks++; if (busyAfter != 0) begin errors++; $display("FAIL zero_busy_end: got %0d want 0", busyAfter); end
  endtask

  task automatic test_single();
    @(negedge clk);
    start_now(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    observe(260);
    checks++; if (evK.size() != 1) begin errors++; $display("FAIL single_hits: got %0d want 1", evK.size()); end
    checks++; if (((evK.size() > 0) ? evK[0] : -1) != 193) begin errors++; $display("FAIL single_ev_time: got %0d want 193", (evK.size() > 0) ? evK[0] : -1); end
    checks++; if (((evPos.size() > 0) ? evPos[0] : -1) != 175) begin errors++; $display("FAIL single_pos: got %0d want 175", (evPos.size() > 0) ? evPos[0] : -1); end
    checks++; if (((evMag.size() > 0) ? evMag[0] : -1) != 'h5A) begin errors++; $display("FAIL single_mag: got %0h want 5a", (evMag.size() > 0) ? evMag[0] : -1); end
    checks++; if (doneK != 194) begin errors++; $display("FAIL single_done_time: got %0d want 194", doneK); end
    checks++; if (doneCnt != 1) begin errors++; $display("FAIL single_count: got %0d want 1", doneCnt); end
    checks++; if (doneUnc != 0) begin errors++; $display("FAIL single_unc: got %0d want 0", doneUnc); end
  endtask

  task automatic test_sigma_fail();
    @(negedge clk);
    start_now(8'h01, 8'h01, 8'h01, 8'h02);
    observe(40);
    checks++; if (doneK != 10) begin errors++; $display("FAIL sigfail_done_time: got %0d want 10", doneK); end
    checks++; if (doneUnc != 1) begin errors++; $display("FAIL sigfail_unc: got %0d want 1", doneUnc); end
    checks++; if (doneCnt != 0) begin errors++; $display("FAIL sigfail_count: got %0d want 0", doneCnt); end
    checks++; if (evK.size() != 0) begin errors++; $display("FAIL sigfail_errvalid: got %0d want 0", evK.size()); end
  endtask

  task automatic test_two_err();
    @(negedge clk);
    start_two();
    observe(260);
    checks++; if (evK.size() != 2) begin errors++; $display("FAIL two_hits: got %0d want 2", evK.size()); end
    checks++; if (((evK.size() > 0) ? evK[0] : -1) != 28) begin errors++; $display("FAIL two_ev0_time: got %0d want 28", (evK.size() > 0) ? evK[0] : -1); end
    checks++; if (((evPos.size() > 0) ? evPos[0] : -1) != 10) begin errors++; $display("FAIL two_ev0_pos: got %0d want 10", (evPos.size() > 0) ? evPos[0] : -1); end
    checks++; if (((evMag.size() > 0) ? evMag[0] : -1) != 'h80) begin errors++; $display("FAIL two_ev0_mag: got %0h want 80", (evMag.size() > 0) ? evMag[0] : -1); end
    checks++; if (((evK.size() > 1) ? evK[1] : -1) != 192) begin errors++; $display("FAIL two_ev1_time: got %0d want 192", (evK.size() > 1) ? evK[1] : -1); end
    checks++; if (((evPos.size() > 1) ? evPos[1] : -1) != 174) begin errors++; $display("FAIL two_ev1_pos: got %0d want 174", (evPos.size() > 1) ? evPos[1] : -1); end
    checks++; if (((evMag.size() > 1) ? evMag[1] : -1) != 'h01) begin errors++; $display("FAIL two_ev1_mag: got %0h want 1", (evMag.size() > 1) ? evMag[1] : -1); end
    checks++; if (doneK != DONE_TWO) begin errors++; $display("FAIL two_done_time: got %0d want %0d", doneK, DONE_TWO); end
    checks++; if (doneCnt != 2 || doneUnc != 0) begin errors++; $display("FAIL two_status: got count %0d unc %0d want 2 0", doneCnt, doneUnc); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    start_two();
    while (cyc - tStart < 50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, errValid, done, uncorrectable, errCount, errPos, errMag} !== 22'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0", {busy, errValid, done, uncorrectable, errCount, errPos, errMag});
    end
    reset = 1'b0;
    pulses = 0;
    repeat (200) begin
      @(negedge clk);
      if (errValid || done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_abandon();
    int pre, post, dn, doneAt, cnt, k;
    pre = 0; post = 0; dn = 0; doneAt = -1; cnt = -1;
    @(negedge clk);
    start_two();
    while (cyc - tStart < 100) begin
      if (errValid) pre++;
      if (done) dn++;
      @(negedge clk);
    end
    s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00;
    synReady = 1'b1;
    @(negedge clk);
    synReady = 1'b0;
    repeat (150) begin
      k = cyc - tStart;
      if (errValid) post++;
      if (done) begin dn++; doneAt = k; cnt = errCount; end
      @(negedge clk);
    end
    checks++; if (pre != 1) begin errors++; $display("FAIL abandon_pre_hits: got %0d want 1", pre); end
    checks++; if (post != 0) begin errors++; $display("FAIL abandon_post_hits: got %0d want 0", post); end
    checks++; if (dn != 1) begin errors++; $display("FAIL abandon_done_count: got %0d want 1", dn); end
    checks++; if (doneAt != 102) begin errors++; $display("FAIL abandon_done_time: got %0d want 102", doneAt); end
    checks++; if (cnt != 0) begin errors++; $display("FAIL abandon_count: got %0d want 0", cnt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_now(8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
    start_now(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    observe(260);
    checks++; if (((evK.size() > 0) ? evK[0] : -1) != 193) begin errors++; $display("FAIL b2b_ev_time: got %0d want 193", (evK.size() > 0) ? evK[0] : -1); end
    checks++; if (doneK != 194) begin errors++; $display("FAIL b2b_done_time: got %0d want 194", doneK); end
    checks++; if (doneCnt != 1) begin errors++; $display("FAIL b2b_count: got %0d want 1", doneCnt); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single();
    test_sigma_fail();
    test_two_err();
    test_reset_mid();
    test_abandon();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
